kb_edit_ctrl: RTL and testbench

Parametrised successor to the keyboard edit controller. Consumes a strobed PS/2 set-2 scan-code stream and decodes E0 extended and F0 break prefixes. Builds an N-digit BCD edit value and a target register address, and presents a commit to the register-file/PicoBlaze side through a valid/ack handshake. Sits between the PS/2 receiver and the clock/date/timer register bank.

---
 rtl/kb_edit_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_kb_edit_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/kb_edit_ctrl.sv
// kb_edit_ctrl: PS/2 set-2 keyboard edit controller.
// Decodes E0/F0 prefixes from a strobed scan-code stream and suppresses
// typematic repeats. It builds a DIGITS-digit BCD edit value and a target
// register address, and offers a commit through a valid/ack handshake.
//
// Optional build macro: KB_KEYPAD_EN enables the numeric keypad digits and
// keypad Enter (E0 5A).
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-high reset
//   ScanCode   byte from the PS/2 receiver
//   ScanValid  one-cycle strobe, ScanCode valid
//   CommitAck  consumer accepted Address/Data (single-cycle pulse)
//   Address    target register address
//   Data       packed BCD edit value, digit 0 in [3:0]
//   Commit     commit pending, held high until CommitAck
//   Cursor     field index within the current group
module kb_edit_ctrl #(
   parameter int unsigned DIGITS     = 2,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIELDS     = 3,
   parameter int unsigned BASE_DATE  = 22,
   parameter int unsigned BASE_CLOCK = 19,
   parameter int unsigned BASE_TIMER = 25,
   parameter int unsigned RING_ADDR  = 28,
   parameter int unsigned RING_ON    = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            ScanCode,
   input  logic                  ScanValid,
   input  logic                  CommitAck,
   output logic [ADDR_W-1:0]     Address,
   output logic [4*DIGITS-1:0]   Data,
   output logic                  Commit,
   output logic [1:0]            Cursor
);

   localparam int unsigned DW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXT    = 2'd1,
      BRK    = 2'd2,
      EXTBRK = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [8:0]        last_q, last_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DW-1:0]     data_d;
   logic [1:0]        cursor_d;
   logic              commit_d;

   logic              make_ev, brk_ev, ev_ext;
   logic [8:0]        key;
   logic              dig_ok;
   logic [3:0]        dig_val;

   assign key = {ev_ext, ScanCode};

   // Digit key decode on the decoded {ext, code} pair
   always_comb begin
      dig_ok  = 1'b1;
      dig_val = 4'd0;
      case (key)
         9'h045: dig_val = 4'd0;
         9'h016: dig_val = 4'd1;
         9'h01E: dig_val = 4'd2;
         9'h026: dig_val = 4'd3;
         9'h025: dig_val = 4'd4;
         9'h02E: dig_val = 4'd5;
         9'h036: dig_val = 4'd6;
         9'h03D: dig_val = 4'd7;
         9'h03E: dig_val = 4'd8;
         9'h046: dig_val = 4'd9;
`ifdef KB_KEYPAD_EN
         9'h070: dig_val = 4'd0;
         9'h069: dig_val = 4'd1;
         9'h072: dig_val = 4'd2;
         9'h07A: dig_val = 4'd3;
         9'h06B: dig_val = 4'd4;
         9'h073: dig_val = 4'd5;
         9'h074: dig_val = 4'd6;
         9'h06C: dig_val = 4'd7;
         9'h075: dig_val = 4'd8;
         9'h07D: dig_val = 4'd9;
`endif
         default: dig_ok = 1'b0;
      endcase
   end

   // Prefix FSM, typematic filter, edit actions and commit handshake
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      addr_d   = Address;
      data_d   = Data;
      cursor_d = Cursor;
      commit_d = Commit;
      make_ev  = 1'b0;
      brk_ev   = 1'b0;
      ev_ext   = 1'b0;

      if (ScanValid) begin
         case (state_q)
            IDLE: begin
               if (ScanCode == 8'hE0)      state_d = EXT;
               else if (ScanCode == 8'hF0) state_d = BRK;
               else                        make_ev = 1'b1;
            end
            EXT: begin
               if (ScanCode == 8'hF0) begin
                  state_d = EXTBRK;
               end else begin
                  make_ev = 1'b1;
                  ev_ext  = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK: begin
               brk_ev  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               brk_ev  = 1'b1;
               ev_ext  = 1'b1;
               state_d = IDLE;
            end
         endcase
      end

      if (brk_ev && key == last_q) last_d = 9'd0;

      // A repeat of the held key is ignored; actions are frozen while a commit is pending
      if (make_ev && key != last_q) begin
         last_d = key;
         if (!Commit) begin
            if (dig_ok) begin
               data_d = (Data << 4) | DW'(dig_val);
            end else begin
               case (key)
                  9'h005: begin addr_d = ADDR_W'(BASE_DATE);  cursor_d = 2'd0; end
                  9'h006: begin addr_d = ADDR_W'(BASE_CLOCK); cursor_d = 2'd0; end
                  9'h004: begin addr_d = ADDR_W'(BASE_TIMER); cursor_d = 2'd0; end
                  9'h00D: begin
                     // Fields are laid out at descending addresses; the last field wraps back
                     if (Cursor == 2'(FIELDS - 1)) begin
                        addr_d   = Address + ADDR_W'(FIELDS - 1);
                        cursor_d = 2'd0;
                     end else begin
                        addr_d   = Address - ADDR_W'(1);
                        cursor_d = Cursor + 2'd1;
                     end
                  end
                  9'h066: data_d = Data >> 4;
                  9'h05A: commit_d = 1'b1;
`ifdef KB_KEYPAD_EN
                  9'h15A: commit_d = 1'b1;
`endif
                  9'h078: begin
                     addr_d   = ADDR_W'(RING_ADDR);
                     data_d   = DW'(RING_ON);
                     commit_d = 1'b1;
                  end
                  9'h007: begin
                     addr_d   = ADDR_W'(RING_ADDR);
                     data_d   = '0;
                     commit_d = 1'b1;
                  end
                  9'h076: begin
                     addr_d   = '0;
                     data_d   = '0;
                     cursor_d = 2'd0;
                  end
                  default: ;
               endcase
            end
         end
      end

      if (Commit && CommitAck) begin
         commit_d = 1'b0;
         addr_d   = '0;
         data_d   = '0;
         cursor_d = 2'd0;
      end
   end

   // State and output registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         last_q  <= 9'd0;
         Address <= '0;
         Data    <= '0;
         Commit  <= 1'b0;
         Cursor  <= 2'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         Address <= addr_d;
         Data    <= data_d;
         Commit  <= commit_d;
         Cursor  <= cursor_d;
      end
   end

endmodule

// File: tb/tb_kb_edit_ctrl.sv
// Directed testbench for kb_edit_ctrl: a default build (2 digits) and a 4-digit
// build share one scan-code stream and are checked against hand-computed values.
module tb_kb_edit_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  scan_code = 8'h00;
   logic        scan_valid = 1'b0;
   logic        commit_ack = 1'b0;

   logic [7:0]  addr2, addr4;
   logic [7:0]  data2;
   logic [15:0] data4;
   logic        commit2, commit4;
   logic [1:0]  cursor2, cursor4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   kb_edit_ctrl u_dut2 (
      .CLK(clk), .RESET(rst), .ScanCode(scan_code), .ScanValid(scan_valid),
      .CommitAck(commit_ack), .Address(addr2), .Data(data2), .Commit(commit2),
      .Cursor(cursor2)
   );

   kb_edit_ctrl #(.DIGITS(4)) u_dut4 (
      .CLK(clk), .RESET(rst), .ScanCode(scan_code), .ScanValid(scan_valid),
      .CommitAck(commit_ack), .Address(addr4), .Data(data4), .Commit(commit4),
      .Cursor(cursor4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Checks both instances; Address/Commit/Cursor are identical across builds
   task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] d2,
                            input logic [15:0] d4, input logic c, input logic [1:0] cur);
      chk({tag, ".addr"},   32'(addr2),   32'(a));
      chk({tag, ".data2"},  32'(data2),   32'(d2));
      chk({tag, ".data4"},  32'(data4),   32'(d4));
      chk({tag, ".commit"}, 32'(commit2), 32'(c));
      chk({tag, ".cursor"}, 32'(cursor2), 32'(cur));
      chk({tag, ".addr4"},  32'(addr4),   32'(a));
      chk({tag, ".cmt4"},   32'(commit4), 32'(c));
      chk({tag, ".cur4"},   32'(cursor4), 32'(cur));
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic key(input logic [7:0] b);
      send_byte(b);
      send_byte(8'hF0);
      send_byte(b);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      commit_ack = 1'b1;
      @(negedge clk);
      commit_ack = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_out("reset", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);
      rst = 1'b0;

      // F2, 1, 5, Enter then ack
      key(8'h06);
      check_out("f2", 8'd19, 8'h00, 16'h0000, 1'b0, 2'd0);
      key(8'h16);
      key(8'h2E);
      key(8'h5A);
      check_out("enter", 8'd19, 8'h15, 16'h0015, 1'b1, 2'd0);
      ack_pulse();
      check_out("ack", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);

      // Five digits then Backspace
      key(8'h16); key(8'h1E); key(8'h26); key(8'h25); key(8'h2E);
      check_out("digits", 8'd0, 8'h45, 16'h2345, 1'b0, 2'd0);
      key(8'h66);
      check_out("bksp", 8'd0, 8'h04, 16'h0234, 1'b0, 2'd0);

      // F1 then Tab x3
      key(8'h76);
      key(8'h05);
      check_out("f1", 8'd22, 8'h00, 16'h0000, 1'b0, 2'd0);
      key(8'h0D);
      check_out("tab1", 8'd21, 8'h00, 16'h0000, 1'b0, 2'd1);
      key(8'h0D);
      check_out("tab2", 8'd20, 8'h00, 16'h0000, 1'b0, 2'd2);
      key(8'h0D);
      check_out("tab3", 8'd22, 8'h00, 16'h0000, 1'b0, 2'd0);

      // Held 7: typematic repeats ignored, new press after break counts
      key(8'h76);
      repeat (4) send_byte(8'h3D);
      check_out("hold", 8'd0, 8'h07, 16'h0007, 1'b0, 2'd0);
      send_byte(8'hF0); send_byte(8'h3D);
      key(8'h3D);
      check_out("repress", 8'd0, 8'h77, 16'h0077, 1'b0, 2'd0);

      // F11 commit, keys dropped while pending
      key(8'h76);
      key(8'h78);
      check_out("f11", 8'd28, 8'h08, 16'h0008, 1'b1, 2'd0);
      key(8'h46);
      key(8'h76);
      check_out("pending", 8'd28, 8'h08, 16'h0008, 1'b1, 2'd0);

      // Ack together with F0: next byte is a break, no action
      @(negedge clk);
      scan_code  = 8'hF0;
      scan_valid = 1'b1;
      commit_ack = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      commit_ack = 1'b0;
      check_out("ack_f0", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);
      send_byte(8'h16);
      check_out("brk_after", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);
      key(8'h16);
      check_out("resume", 8'd0, 8'h01, 16'h0001, 1'b0, 2'd0);

      // F12 commits zero to the ring address
      key(8'h07);
      check_out("f12", 8'd28, 8'h00, 16'h0000, 1'b1, 2'd0);
      ack_pulse();

      // Extended up arrow: no action; plain 75 is keypad 8 only when enabled
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check_out("uparrow", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);
      key(8'h75);
`ifdef KB_KEYPAD_EN
      check_out("keypad", 8'd0, 8'h08, 16'h0008, 1'b0, 2'd0);
`else
      check_out("keypad", 8'd0, 8'h00, 16'h0000, 1'b0, 2'd0);
`endif

      // Address wrap below zero, and ack with no commit pending is ignored
      key(8'h76);
      key(8'h0D);
      check_out("wrap", 8'd255, 8'h00, 16'h0000, 1'b0, 2'd1);
      ack_pulse();
      check_out("idle_ack", 8'd255, 8'h00, 16'h0000, 1'b0, 2'd1);

      // Reset after E0 discards the prefix
      send_byte(8'hE0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      key(8'h16);
      check_out("rst_mid", 8'd0, 8'h01, 16'h0001, 1'b0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
